// File: rtl/x9_run_ctrl.sv
// x9_run_ctrl: start/finish handshake around the X9 core; define X9_RUN_CTRL_WDOG_EN to build the RUN watchdog
module x9_run_ctrl #(
    parameter int CW      = 16,
    parameter int RST_CYC = 2,
    parameter int TIMEOUT = 4095
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          core_done,
    output logic          core_reset,
    output logic          busy,
    output logic          ack,
    output logic [CW-1:0] cycles,
    output logic          timeout
);
    typedef enum logic [1:0] {IDLE, HOLD, RUN, ACK} state_t;
    state_t        state, state_n;
    logic [7:0]    hold_cnt, hold_cnt_n;
    logic          core_reset_n, busy_n, ack_n, timeout_n, wdog;
    logic [CW-1:0] cycles_n, cycles_sat;
    logic [CW:0]   cyc_inc;
    assign cyc_inc    = {1'b0, cycles} + (CW+1)'(1);
    assign cycles_sat = cyc_inc[CW] ? cycles : cyc_inc[CW-1:0];
`ifdef X9_RUN_CTRL_WDOG_EN
    assign wdog = !core_done && cyc_inc == (CW+1)'(TIMEOUT);
`else
    assign wdog = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            core_reset <= 1'b1;
            busy       <= 1'b0;
            ack        <= 1'b0;
            cycles     <= '0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_n;
            hold_cnt   <= hold_cnt_n;
            core_reset <= core_reset_n;
            busy       <= busy_n;
            ack        <= ack_n;
            cycles     <= cycles_n;
            timeout    <= timeout_n;
        end
    end
    always_comb begin
        state_n      = state;
        hold_cnt_n   = hold_cnt;
        core_reset_n = core_reset;
        busy_n       = busy;
        ack_n        = 1'b0;
        cycles_n     = cycles;
        timeout_n    = timeout;
        case (state)
            IDLE: if (req) begin
                state_n      = HOLD;
                hold_cnt_n   = '0;
                core_reset_n = 1'b1;
                busy_n       = 1'b1;
                cycles_n     = '0;
                timeout_n    = 1'b0;
            end
            HOLD: begin
                hold_cnt_n = hold_cnt + 8'd1;
                if (hold_cnt == 8'(RST_CYC - 1)) begin
                    state_n      = RUN;
                    core_reset_n = 1'b0;
                end
            end
            RUN: begin
                cycles_n = cycles_sat;
                if (core_done || wdog) begin
                    state_n      = ACK;
                    ack_n        = 1'b1;
                    core_reset_n = 1'b1;
                    timeout_n    = wdog;
                end
            end
            ACK: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_x9_run_ctrl.sv
// tb_x9_run_ctrl: directed checks of the run controller, main instance plus a 4-bit counter instance
module tb_x9_run_ctrl;
    logic clk = 1'b0, reset = 1'b1;
    logic req = 1'b0, done = 1'b0, req4 = 1'b0, done4 = 1'b0;
    logic core_reset, busy, ack, timeout;
    logic core_reset4, busy4, ack4, timeout4;
    logic [15:0] cycles;
    logic [3:0]  cycles4;
    int checks = 0, errors = 0, ack_cnt = 0, ack4_cnt = 0, a0;

    x9_run_ctrl #(.CW(16), .RST_CYC(2), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .req(req), .core_done(done),
        .core_reset(core_reset), .busy(busy), .ack(ack), .cycles(cycles), .timeout(timeout));

    x9_run_ctrl #(.CW(4), .RST_CYC(2), .TIMEOUT(15)) dut4 (
        .clk(clk), .reset(reset), .req(req4), .core_done(done4),
        .core_reset(core_reset4), .busy(busy4), .ack(ack4), .cycles(cycles4), .timeout(timeout4));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ack) ack_cnt++;
        if (ack4) ack4_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not end, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_main(input int n, input bit poke);
        a0 = ack_cnt;
        req = 1'b1;
        tick;
        chk("run_busy_accept", busy, 1);
        chk("run_cr_accept", core_reset, 1);
        req = poke;
        tick;
        chk("run_cr_hold", core_reset, 1);
        tick;
        chk("run_cr_release", core_reset, 0);
        for (int i = 1; i <= n; i++) begin
            done = (i == n);
            tick;
        end
        done = 1'b0;
        chk("run_ack", ack, 1);
        chk("run_cycles", cycles, n);
        chk("run_busy_ack", busy, 1);
        chk("run_cr_ack", core_reset, 1);
        tick;
        chk("run_ack_fall", ack, 0);
        chk("run_busy_fall", busy, 0);
        req = 1'b0;
        tick;
        chk("run_no_restart", busy, 0);
        chk("run_cycles_hold", cycles, n);
        chk("run_ack_once", ack_cnt - a0, 1);
    endtask

    initial begin
        tick;
        tick;
        reset = 1'b0;
        chk("rst_core_reset", core_reset, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ack", ack, 0);
        chk("rst_cycles", cycles, 0);
        chk("rst_timeout", timeout, 0);
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("idle_core_reset", core_reset, 1);
            chk("idle_busy", busy, 0);
            chk("idle_ack", ack, 0);
            chk("idle_cycles", cycles, 0);
            chk("idle_timeout", timeout, 0);
        end

        // req at edge 0, done sampled at edge 7 (5th RUN edge)
        req = 1'b1;
        tick;
        chk("t_busy_e0", busy, 1);
        chk("t_cr_e0", core_reset, 1);
        req = 1'b0;
        tick;
        chk("t_cr_e1", core_reset, 1);
        tick;
        chk("t_cr_e2", core_reset, 0);
        for (int e = 3; e <= 6; e++) begin
            tick;
            chk("t_cr_run", core_reset, 0);
            chk("t_ack_run", ack, 0);
            chk("t_cycles_run", cycles, e - 2);
        end
        done = 1'b1;
        tick;
        done = 1'b0;
        chk("t_ack_e7", ack, 1);
        chk("t_cycles_e7", cycles, 5);
        chk("t_busy_e7", busy, 1);
        chk("t_cr_e7", core_reset, 1);
        tick;
        chk("t_ack_e8", ack, 0);
        chk("t_busy_e8", busy, 0);
        chk("t_cycles_e8", cycles, 5);
        chk("t_timeout_e8", timeout, 0);
        chk("t_ack_count", ack_cnt, 1);

        run_main(5, 1'b1);
        run_main(1, 1'b0);

        // reset on the 3rd RUN edge
        a0 = ack_cnt;
        req = 1'b1;
        tick;
        req = 1'b0;
        tick;
        tick;
        tick;
        tick;
        chk("mid_cycles_pre", cycles, 2);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("mid_core_reset", core_reset, 1);
        chk("mid_busy", busy, 0);
        chk("mid_cycles", cycles, 0);
        chk("mid_ack", ack, 0);
        tick;
        chk("mid_idle_busy", busy, 0);
        chk("mid_no_ack", ack_cnt - a0, 0);

`ifdef X9_RUN_CTRL_WDOG_EN
        a0 = ack_cnt;
        req = 1'b1;
        tick;
        req = 1'b0;
        tick;
        tick;
        for (int i = 1; i <= 8; i++) tick;
        chk("wd_ack", ack, 1);
        chk("wd_cycles", cycles, 8);
        chk("wd_timeout", timeout, 1);
        tick;
        tick;
        chk("wd_timeout_hold", timeout, 1);
        chk("wd_ack_once", ack_cnt - a0, 1);
        run_main(8, 1'b0);
        chk("wd_done_wins", timeout, 0);
`else
        run_main(12, 1'b0);
        chk("nowd_timeout", timeout, 0);
`endif

        // 4-bit counter saturates at 15
        req4 = 1'b1;
        tick;
        req4 = 1'b0;
        tick;
        tick;
        for (int i = 1; i <= 20; i++) begin
            done4 = (i == 20);
            tick;
        end
        done4 = 1'b0;
        tick;
        tick;
        chk("sat_cycles", cycles4, 15);
        chk("sat_ack_once", ack4_cnt, 1);
        chk("sat_busy", busy4, 0);
`ifdef X9_RUN_CTRL_WDOG_EN
        chk("sat_timeout", timeout4, 1);
`else
        chk("sat_timeout", timeout4, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
